// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds the FSM state encoding and the funct3 width/sign codes.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores only know B/H/W; loads additionally allow the unsigned forms.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        end
        return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W) &&
               (f3 != F3_BU) && (f3 != F3_HU);
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core request/response and RAM data-port signals of the load/store unit.
// The LSU uses the slave view; the core/RAM side uses the master view.
interface riscv_lsu_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2:0]             req_funct3;
    logic [WORD_LENGTH-1:0] req_addr;
    logic [WORD_LENGTH-1:0] req_wdata;
    logic                   resp_valid;
    logic [WORD_LENGTH-1:0] resp_rdata;
    logic                   resp_fault;
    logic [WORD_LENGTH-1:0] mem_addr;
    logic                   mem_write_en;
    logic [WORD_LENGTH-1:0] mem_wdata;
    logic [WORD_LENGTH-1:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_write_en, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_write_en, mem_wdata
    );
endinterface

// File: rtl/riscv_lsu_align.sv
// Combinational data path: load extraction/extension and sub-word store merge.
// The RAM word is always read starting at the access address, so data sits in the low bits.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [2:0]             funct3_i,
    input  logic [WORD_LENGTH-1:0] dout_i,
    input  logic [15:0]            wdata_i,
    output logic [WORD_LENGTH-1:0] load_data_o,
    output logic [WORD_LENGTH-1:0] merged_o
);

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{(WORD_LENGTH-8){dout_i[7]}}, dout_i[7:0]};
            F3_H:    load_data_o = {{(WORD_LENGTH-16){dout_i[15]}}, dout_i[15:0]};
            F3_W:    load_data_o = dout_i;
            F3_BU:   load_data_o = {{(WORD_LENGTH-8){1'b0}}, dout_i[7:0]};
            F3_HU:   load_data_o = {{(WORD_LENGTH-16){1'b0}}, dout_i[15:0]};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        merged_o = dout_i;
        case (funct3_i)
            F3_B:    merged_o = {dout_i[WORD_LENGTH-1:8], wdata_i[7:0]};
            F3_H:    merged_o = {dout_i[WORD_LENGTH-1:16], wdata_i[15:0]};
            default: merged_o = dout_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit in front of a byte-addressed RAM with a 4-byte write port.
// Sub-word stores are read-modify-write through an extra WRITE state.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_MEM     = 16384
) (
    input  logic         clk,
    input  logic         rst,
    riscv_lsu_if.slave   bus
);

    localparam logic [WORD_LENGTH-1:0] MAX_ADDR = WORD_LENGTH'(NUM_MEM - 4);

    lsu_state_t             state_q, state_d;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
    logic [WORD_LENGTH-1:0] merged_q, merged_d;

    logic [WORD_LENGTH-1:0] load_data;
    logic [WORD_LENGTH-1:0] merged;
    logic                   fault;

    riscv_lsu_align #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_align (
        .funct3_i    (funct3_q),
        .dout_i      (bus.mem_dout),
        .wdata_i     (wdata_q[15:0]),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    assign fault = (addr_q > MAX_ADDR) || f3_illegal(we_q, funct3_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        merged_d         = merged_q;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.resp_fault   = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_write_en = 1'b0;
        bus.mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_addr = addr_q;
                if (fault) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_fault = 1'b1;
                    state_d        = IDLE;
                end else if (!we_q) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = load_data;
                    state_d        = IDLE;
                end else if (funct3_q == F3_W) begin
                    bus.mem_write_en = 1'b1;
                    bus.mem_wdata    = wdata_q;
                    bus.resp_valid   = 1'b1;
                    state_d          = IDLE;
                end else begin
                    merged_d = merged;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                bus.mem_addr     = addr_q;
                bus.mem_write_en = 1'b1;
                bus.mem_wdata    = merged_q;
                bus.resp_valid   = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so the outputs must be silenced combinationally or
        // an in-flight write would still commit on the reset edge.
        if (rst) begin
            bus.req_ready    = 1'b0;
            bus.resp_valid   = 1'b0;
            bus.resp_rdata   = '0;
            bus.resp_fault   = 1'b0;
            bus.mem_addr     = '0;
            bus.mem_write_en = 1'b0;
            bus.mem_wdata    = '0;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a byte-addressed RAM model behind the data port.
// Expected values are hand-computed from the little-endian byte layout.
module tb_riscv_lsu;

    localparam int WL      = 32;
    localparam int NUM_MEM = 16384;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] ram [NUM_MEM];

    riscv_lsu_if #(.WORD_LENGTH(WL)) bus ();

    riscv_lsu #(
        .WORD_LENGTH (WL),
        .NUM_MEM     (NUM_MEM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read of addr..addr+3, 4-byte write on the clock edge.
    always_comb begin
        bus.mem_dout = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(bus.mem_addr) + i < NUM_MEM)
                bus.mem_dout[8*i +: 8] = ram[int'(bus.mem_addr) + i];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (int'(bus.mem_addr) + i < NUM_MEM)
                    ram[int'(bus.mem_addr) + i] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; lat=0 means no response.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic fault,
                                 output int lat, output int wr);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rdata = '0;
        fault = 1'b0;
        lat   = 0;
        wr    = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.mem_write_en) wr++;
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                fault = bus.resp_fault;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runCase(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expData, input logic expFault,
                           input int expLat, input int expWr);
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          wr;
        applyStimulus(we, f3, addr, wdata, rdata, fault, lat, wr);
        checkOutput({tag, ".lat"},   32'(lat),   32'(expLat));
        checkOutput({tag, ".data"},  rdata,      expData);
        checkOutput({tag, ".fault"}, 32'(fault), 32'(expFault));
        checkOutput({tag, ".wr"},    32'(wr),    32'(expWr));
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.ready", 32'(bus.req_ready),    32'd0);
        checkOutput("rst.valid", 32'(bus.resp_valid),   32'd0);
        checkOutput("rst.we",    32'(bus.mem_write_en), 32'd0);
        checkOutput("rst.addr",  bus.mem_addr,          32'd0);
        rst = 1'b0;
        #1 checkOutput("idle.ready", 32'(bus.req_ready), 32'd1);

        // Loads of 0x8899AABB: bytes 0x100..0x103 = BB AA 99 88
        runCase("sw100a", 1'b1, 3'd2, 32'h100, 32'h8899AABB, 32'h0, 1'b0, 1, 1);
        runCase("lw100",  1'b0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 1, 0);
        runCase("lb102",  1'b0, 3'd0, 32'h102, 32'h0, 32'hFFFFFF99, 1'b0, 1, 0);
        runCase("lbu102", 1'b0, 3'd4, 32'h102, 32'h0, 32'h00000099, 1'b0, 1, 0);
        runCase("lh101",  1'b0, 3'd1, 32'h101, 32'h0, 32'hFFFF99AA, 1'b0, 1, 0);
        runCase("lhu100", 1'b0, 3'd5, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 1, 0);

        // Sub-word stores go through read-modify-write
        runCase("sw100b", 1'b1, 3'd2, 32'h100, 32'h11223344, 32'h0, 1'b0, 1, 1);
        runCase("sb101",  1'b1, 3'd0, 32'h101, 32'h0000005A, 32'h0, 1'b0, 2, 1);
        runCase("lw100b", 1'b0, 3'd2, 32'h100, 32'h0, 32'h11225A44, 1'b0, 1, 0);
        runCase("sh102",  1'b1, 3'd1, 32'h102, 32'hFFFFBEEF, 32'h0, 1'b0, 2, 1);
        runCase("lw100c", 1'b0, 3'd2, 32'h100, 32'h0, 32'hBEEF5A44, 1'b0, 1, 0);

        runCase("sw200",  1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1);
        runCase("lhu202", 1'b0, 3'd5, 32'h202, 32'h0, 32'h0000DEAD, 1'b0, 1, 0);

        // Address boundary and illegal funct3
        runCase("swtop",  1'b1, 3'd2, 32'(NUM_MEM-4), 32'hCAFEF00D, 32'h0, 1'b0, 1, 1);
        runCase("lwtop",  1'b0, 3'd2, 32'(NUM_MEM-4), 32'h0, 32'hCAFEF00D, 1'b0, 1, 0);
        runCase("lwover", 1'b0, 3'd2, 32'(NUM_MEM-2), 32'h0, 32'h0, 1'b1, 1, 0);
        runCase("sbover", 1'b1, 3'd0, 32'(NUM_MEM-3), 32'h12, 32'h0, 1'b1, 1, 0);
        runCase("sf3_3",  1'b1, 3'd3, 32'h100, 32'h12345678, 32'h0, 1'b1, 1, 0);
        runCase("lf3_6",  1'b0, 3'd6, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
        runCase("lw100d", 1'b0, 3'd2, 32'h100, 32'h0, 32'hBEEF5A44, 1'b0, 1, 0);

        // Reset during the WRITE cycle of an SB must drop it entirely
        runCase("sw300",  1'b1, 3'd2, 32'h300, 32'hAABBCCDD, 32'h0, 1'b0, 1, 1);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h300;
        bus.req_wdata  = 32'h00000011;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstw.valid", 32'(bus.resp_valid),   32'd0);
        checkOutput("rstw.we",    32'(bus.mem_write_en), 32'd0);
        checkOutput("rstw.ready", 32'(bus.req_ready),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstw.valid2", 32'(bus.resp_valid), 32'd0);
        checkOutput("rstw.ready2", 32'(bus.req_ready),  32'd1);
        runCase("lw300",  1'b0, 3'd2, 32'h300, 32'h0, 32'hAABBCCDD, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
